// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU: control codes, operation field and FSM states.
// The optional overflow port is enabled by ALU_OVF_FLAG_EN in alu_serial.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1110;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_LESS = 2'b01,
        OP_OR   = 2'b10,
        OP_ADD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_legal(input logic [3:0] code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT) || (code == ALU_NOR) ||
               (code == ALU_NAND);
    endfunction

    function automatic logic is_arith(input logic [3:0] code);
        return (code == ALU_ADD) || (code == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational chain of SLICE one-bit ALU cells; exposes the carry into the top bit
// and the top-bit sum so the caller can derive signed overflow and the SLT set bit.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ainv,
    input  logic             binv,
    input  logic             cin,
    input  op_e              op,
    output logic [SLICE-1:0] res,
    output logic             sum_top,
    output logic             cout,
    output logic             ctop
);

    logic c;
    logic ai;
    logic bi;

    always_comb begin
        c       = cin;
        ctop    = cin;
        sum_top = 1'b0;
        res     = '0;
        ai      = 1'b0;
        bi      = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            ai = a[i] ^ ainv;
            bi = b[i] ^ binv;
            if (i == SLICE - 1) begin
                ctop    = c;
                sum_top = ai ^ bi ^ c;
            end
            case (op)
                OP_AND:  res[i] = ai & bi;
                OP_OR:   res[i] = ai | bi;
                OP_ADD:  res[i] = ai ^ bi ^ c;
                default: res[i] = 1'b0;
            endcase
            c = (ai & bi) | (ai & c) | (bi & c);
        end
        cout = c;
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU processing SLICE bits per cycle LSB-first with a registered ripple carry.
// Define ALU_OVF_FLAG_EN to add the registered signed-overflow output port.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout
`ifdef ALU_OVF_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_res;
    logic             s_sum_top;
    logic             s_cout;
    logic             s_ctop;
    logic             legal;
    logic             arith;
    logic             msb_ovf;

    assign a_sl    = a_q[int'(cnt) * SLICE +: SLICE];
    assign b_sl    = b_q[int'(cnt) * SLICE +: SLICE];
    assign legal   = is_legal(ctrl_q);
    assign arith   = is_arith(ctrl_q);
    assign msb_ovf = s_ctop ^ s_cout;
    assign zero    = (result == '0);

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a       (a_sl),
        .b       (b_sl),
        .ainv    (ctrl_q[3]),
        .binv    (ctrl_q[2]),
        .cin     (carry),
        .op      (op_e'(ctrl_q[1:0])),
        .res     (s_res),
        .sum_top (s_sum_top),
        .cout    (s_cout),
        .ctop    (s_ctop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            overflow  <= 1'b0;
`endif
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= src1;
                        b_q      <= src2;
                        ctrl_q   <= alu_ctrl;
                        cnt      <= '0;
                        carry    <= alu_ctrl[2];
                        in_ready <= 1'b0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Unsupported codes still run their slices but write zeros.
                    result[int'(cnt) * SLICE +: SLICE] <= legal ? s_res : '0;
                    carry <= s_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        cout      <= arith ? s_cout : 1'b0;
`ifdef ALU_OVF_FLAG_EN
                        overflow  <= arith ? msb_ovf : 1'b0;
`endif
                        // SLT slices emit zero; the set bit lands in bit 0 here.
                        if (ctrl_q == ALU_SLT) begin
                            result[0] <= s_sum_top ^ msb_ovf;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
